// File: rtl/adder_arb_pkg.sv
// Shared constants and operation encoding for the arbitrated add/sub unit.
package adder_arb_pkg;

    localparam int W_DEF    = 32;
    localparam int NREQ_DEF = 4;
    localparam int ID_W_DEF = $clog2(NREQ_DEF);
    localparam int CNT_W    = 32;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/adder_arb_cla.sv
// Add/subtract datapath built from 4-bit carry-lookahead groups chained by group carry.
module adder_arb_cla #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    localparam int NG = (W + 3) / 4;
    localparam int WP = NG * 4;

    logic [WP-1:0] a_x, b_x, g, p, c, s;
    logic          gc;

    always_comb begin
        a_x = '0;
        b_x = '0;
        a_x[W-1:0] = a;
        b_x[W-1:0] = sub ? ~b : b;
        g  = a_x & b_x;
        p  = a_x ^ b_x;
        c  = '0;
        gc = sub;
        for (int k = 0; k < NG; k++) begin
            c[4*k]   = gc;
            c[4*k+1] = g[4*k] | (p[4*k] & gc);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc);
            // Group carry-out feeds the next group; the final one is the discarded carry.
            gc = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc);
        end
        s = p ^ c;
    end

    assign sum = s[W-1:0];

endmodule

// File: rtl/adder_arb_rr_pick.sv
// Combinational round-robin select: first set request at or above the pointer, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(ptr) + k) % NREQ]) begin
                any = 1'b1;
                grant[(int'(ptr) + k) % NREQ] = 1'b1;
                idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/adder_arb.sv
// Round-robin arbitrated shared add/sub unit with a single-entry result slot.
module adder_arb
    import adder_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int W    = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    input  logic [NREQ-1:0]          req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [W-1:0]             rsp_r,
    output logic [CNT_W-1:0]         op_count
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [W-1:0]     rsp_r_q, rsp_r_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            can_accept;
    logic            transfer;
    logic [W-1:0]    a_sel, b_sel, sum;
    op_e             op_sel;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The slot refills in the same cycle it drains, so throughput is one result per cycle.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign transfer   = pick_any && can_accept && !rst;
    assign req_ready  = rst ? '0 : (grant & {NREQ{can_accept}});

    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        op_sel = OP_ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                a_sel  = req_a[i*W +: W];
                b_sel  = req_b[i*W +: W];
                op_sel = req_sub[i] ? OP_SUB : OP_ADD;
            end
        end
    end

    adder_arb_cla #(.W(W)) u_cla (
        .a   (a_sel),
        .b   (b_sel),
        .sub (op_sel == OP_SUB),
        .sum (sum)
    );

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_r_d     = rsp_r_q;
        op_count_d  = op_count_q;
        if (transfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = pick_idx;
            rsp_r_d     = sum;
            op_count_d  = op_count_q + 1'b1;
            ptr_d       = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_r_q     <= '0;
            op_count_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_r_q     <= rsp_r_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_r     = rsp_r_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arb.sv
// Randomized and directed bench for adder_arb against a queue-based result model.
module tb_adder_arb;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*W-1:0]      req_a;
    logic [NREQ*W-1:0]      req_b;
    logic [NREQ-1:0]        req_sub;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic [W-1:0]           rsp_r;
    logic [31:0]            op_count;

    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];

    int total = 0;
    int bad   = 0;

    // Model state: pending result queue (at most one entry), pointer, counter, last shown result.
    logic [IDW+W-1:0] exp_q[$];
    int               m_ptr;
    logic [31:0]      m_cnt;
    logic [IDW+W-1:0] m_last;

    adder_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_r     (rsp_r),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a_arr[i];
            req_b[i*W +: W] = b_arr[i];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int first_valid(input logic [NREQ-1:0] v, input int from);
        for (int k = 0; k < NREQ; k++)
            if (v[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_ptr  = 0;
            m_cnt  = '0;
            m_last = '0;
        end else begin
            int g;
            logic can;
            logic [W-1:0] res;
            can = (exp_q.size() == 0) || rsp_ready;
            g   = first_valid(req_valid, m_ptr);
            if (exp_q.size() != 0 && rsp_ready) m_last = exp_q.pop_front();
            if (g >= 0 && can) begin
                res = req_sub[g] ? a_arr[g] - b_arr[g] : a_arr[g] + b_arr[g];
                exp_q.push_back({IDW'(g), res});
                m_ptr = (g + 1) % NREQ;
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0]  exp_ready;
        logic [IDW+W-1:0] shown;
        int g;
        exp_ready = '0;
        g = first_valid(req_valid, m_ptr);
        if (!rst && g >= 0 && (exp_q.size() == 0 || rsp_ready)) exp_ready[g] = 1'b1;
        shown = (exp_q.size() != 0) ? exp_q[0] : m_last;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
        check("rsp_id",    64'(rsp_id),    64'(shown[IDW+W-1:W]));
        check("rsp_r",     64'(rsp_r),     64'(shown[W-1:0]));
        check("op_count",  64'(op_count),  64'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        req_sub   = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [IDW-1:0] ids [6];
        logic [IDW-1:0] want [6];
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_inputs();
        #2;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_op_count",  64'(op_count),  64'd0);
        check("reset_rsp_r",     64'(rsp_r),     64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;

        // Single requester 2 subtracting.
        req_valid = 4'b0100; a_arr[2] = 5; b_arr[2] = 3; req_sub = 4'b0100; rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        #1;
        check("d034_valid", 64'(rsp_valid), 64'd1);
        check("d034_id",    64'(rsp_id),    64'd2);
        check("d034_r",     64'(rsp_r),     64'd2);
        check("d034_count", 64'(op_count),  64'd1);

        // All requesters continuously valid: rotation from pointer 0.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        want = '{0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = $urandom;
                b_arr[i] = $urandom;
            end
            req_sub = NREQ'($urandom_range(0, 15));
            tick();
            #1;
            ids[k] = rsp_id;
            check("d035_valid", 64'(rsp_valid), 64'd1);
        end
        for (int k = 0; k < 6; k++) check("d035_seq", 64'(ids[k]), 64'(want[k]));

        // Wraparound add and borrow subtract.
        do_reset();
        req_valid = 4'b0001; a_arr[0] = 32'hFFFF_FFFF; b_arr[0] = 1; req_sub = 4'b0000;
        tick();
        #1;
        check("d036_add_wrap", 64'(rsp_r), 64'd0);
        req_valid = 4'b0010; a_arr[1] = 0; b_arr[1] = 1; req_sub = 4'b0010;
        tick();
        req_valid = '0;
        #1;
        check("d036_sub_wrap", 64'(rsp_r), 64'hFFFF_FFFF);

        // Backpressure with requesters 1 and 3 waiting.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001; a_arr[0] = 7; b_arr[0] = 9;
        tick();
        req_valid = 4'b1010;
        a_arr[1] = 100; b_arr[1] = 1; a_arr[3] = 300; b_arr[3] = 3;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("d037_stall_ready", 64'(req_ready), 64'd0);
            check("d037_stall_r",     64'(rsp_r),     64'd16);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("d037_ready_1", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1000;
        #1;
        check("d037_id_1",    64'(rsp_id),    64'd1);
        check("d037_r_1",     64'(rsp_r),     64'd101);
        check("d037_ready_3", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0;
        #1;
        check("d037_id_3", 64'(rsp_id), 64'd3);
        check("d037_r_3",  64'(rsp_r),  64'd303);

        // Reset while a result is held and two requests pend.
        do_reset();
        rsp_ready = 1'b0;
        req_valid = 4'b0001; a_arr[0] = 1; b_arr[0] = 1;
        tick();
        req_valid = 4'b1100; a_arr[2] = 20; b_arr[2] = 2; a_arr[3] = 30; b_arr[3] = 3;
        rst = 1'b1;
        #1;
        check("d038_rst_valid", 64'(rsp_valid), 64'd0);
        check("d038_rst_r",     64'(rsp_r),     64'd0);
        check("d038_rst_count", 64'(op_count),  64'd0);
        check("d038_rst_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("d038_first_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        check("d038_first_id", 64'(rsp_id), 64'd2);

        // Counter wrap.
        rsp_ready = 1'b1;
        tick();
        dut.op_count_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        req_valid = 4'b0001;
        tick();
        #1;
        check("d039_count_max", 64'(op_count), 64'hFFFF_FFFF);
        tick();
        req_valid = '0;
        #1;
        check("d039_count_wrap", 64'(op_count), 64'd0);

        // Random traffic.
        do_reset();
        for (int n = 0; n < 500; n++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            req_sub   = NREQ'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                b_arr[i] = $urandom;
            end
            if (n == 250) rst = 1'b1;
            if (n == 252) rst = 1'b0;
            tick();
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 32, operand/result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_ready  output  NREQ  per-requester accept; at most one bit set per cycle.
REQ-007 req_a  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-008 req_b  input  NREQ*W  packed operand B, same packing.
REQ-009 req_sub  input  NREQ  1 = A-B, 0 = A+B, per requester.
REQ-010 rsp_valid  output  1  result slot holds a valid result.
REQ-011 rsp_ready  input  1  consumer takes result this cycle.
REQ-012 rsp_id  output  clog2(NREQ)  index of requester that owns the result.
REQ-013 rsp_r  output  W  result, modulo 2^W.
REQ-014 op_count  output  32  completed-operation counter.

Function
REQ-015 Transfer on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 Slot can accept when rsp_valid=0, or rsp_valid=1 and rsp_ready=1 (same-cycle drain and refill).
REQ-017 req_ready[i] = grant[i] AND slot-can-accept; grant is combinational from req_valid and pointer; no dependence of req_ready on requester holding valid beyond current cycle.
REQ-018 Round-robin: grant goes to first i with req_valid[i]=1 searching from pointer upward modulo NREQ.
REQ-019 Pointer resets to 0; on a transfer from requester i pointer becomes (i+1) mod NREQ; otherwise pointer holds.
REQ-020 Granted operands drive one shared add/sub datapath: B inverted and carry-in = 1 when req_sub=1; carry-out discarded.
REQ-021 Latency: result, rsp_id registered on transfer edge; rsp_valid = 1 the following cycle.
REQ-022 rsp_valid, rsp_id, rsp_r hold stable while rsp_valid=1 and rsp_ready=0.
REQ-023 Slot full and rsp_ready=0: all req_ready = 0, pointer holds, no state change.
REQ-024 rsp_ready=1 with no transfer: rsp_valid clears next cycle; rsp_r, rsp_id keep last value.
REQ-025 op_count increments by 1 on every transfer; wraps 0xFFFFFFFF -> 0.
REQ-026 No req_valid set: no grant, no state change besides slot drain.
REQ-027 Requesters shall hold req_valid and payload until accepted; arbiter does not require it for correctness.

Reset
REQ-028 rst=1 asynchronously forces rsp_valid=0, rsp_id=0, rsp_r=0, op_count=0, pointer=0.
REQ-029 Reset mid-operation discards a held result; req_ready = 0 while rst=1.
REQ-030 First transfer possible on first rising edge with rst=0.

Structure
REQ-031 Shared package holds W default, NREQ default, ID-width constant, op encoding (ADD=0, SUB=1).
REQ-032 One sub-module rr_pick: combinational round-robin select (req vector, pointer -> one-hot grant, index).
REQ-033 Existing 32-bit carry-lookahead adder with sub control is instantiated once as the shared datapath; no second adder.

Verification
REQ-034 Req 2 only, A=5, B=3, sub=1, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_id=2, rsp_r=2, op_count=1.
REQ-035 All four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1, one result per cycle.
REQ-036 Req 0 A=0xFFFFFFFF B=1 add -> rsp_r=0; req 1 A=0 B=1 sub -> rsp_r=0xFFFFFFFF.
REQ-037 rsp_ready=0 for 3 cycles with slot full, req 1 and 3 valid -> req_ready=0, rsp stable; on rsp_ready=1 req 1 accepted same cycle, then 3.
REQ-038 rst asserted while rsp_valid=1 and two requests pending -> outputs zero immediately; after release first grant to lowest valid index from pointer 0.
REQ-039 Force op_count to 0xFFFFFFFE, two transfers -> op_count 0xFFFFFFFF then 0.
